mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4-bit 2:1 Multiplexer datapath. It shares one registered output channel between two requesters and drives the mux Selector. It issues per-beat acknowledges and presents data downstream with a Valid/Ready handshake. Sits between two producer blocks (e.g. switch or counter sources on Basys3) and a single consumer (e.g. a 7-segment driver).

---
 rtl/mux_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mux_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter/sequencer for a 2:1 mux datapath.
// Two requesters share one registered output channel (DataOut/Valid/Ready).
// Optional build macro MUX_ARB_COUNT_EN adds per-requester ack counters
// (Count0/Count1, 8 bits, wrapping).
//
// Handshake: a beat moves downstream on any edge where Valid & Ready are both
// high. The output slot is free when ~Valid | Ready, so a consume and a new
// capture can happen on the same edge without a bubble. Ack0/Ack1 are
// combinational pulses in the cycle whose closing edge captures the data.
module mux_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             Req0,
   input  logic [WIDTH-1:0] In0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] In1,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Selector,
   output logic [WIDTH-1:0] DataOut,
   output logic             Valid,
   input  logic             Ready,
   output logic [1:0]       dbg_state
`ifdef MUX_ARB_COUNT_EN
   ,
   output logic [7:0]       Count0,
   output logic [7:0]       Count1
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

   state_t     state, state_nxt;
   logic [3:0] beat_cnt, beat_cnt_nxt, beat_inc;
   logic       last_grant, last_grant_nxt;
   logic       sel_nxt;
   logic       slot_free, acc0, acc1, accept, hold_hit;

   assign dbg_state = state;
   assign Ack0      = acc0;
   assign Ack1      = acc1;

   // Accept decode: the owner captures when it still requests and the slot is free.
   always_comb begin
      slot_free = ~Valid | Ready;
      acc0      = (state == GRANT0) & Req0 & slot_free;
      acc1      = (state == GRANT1) & Req1 & slot_free;
      accept    = acc0 | acc1;
      beat_inc  = beat_cnt + 4'd1;
      hold_hit  = accept & (beat_inc == HOLD_LIM);
   end

   // Next-state: grant selection, release, and hold-limit hand-over.
   always_comb begin
      state_nxt      = state;
      beat_cnt_nxt   = beat_cnt;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            // On a tie the requester that did not own the channel last wins.
            if (Req0 && Req1) state_nxt = last_grant ? GRANT0 : GRANT1;
            else if (Req0)    state_nxt = GRANT0;
            else if (Req1)    state_nxt = GRANT1;
         end
         GRANT0: begin
            if (!Req0) begin
               state_nxt      = Req1 ? GRANT1 : IDLE;
               beat_cnt_nxt   = 4'd0;
               last_grant_nxt = 1'b0;
            end else if (hold_hit) begin
               // Limit reached: hand over only if the other side is waiting.
               beat_cnt_nxt = 4'd0;
               if (Req1) begin
                  state_nxt      = GRANT1;
                  last_grant_nxt = 1'b0;
               end
            end else if (acc0) begin
               beat_cnt_nxt = beat_inc;
            end
         end
         GRANT1: begin
            if (!Req1) begin
               state_nxt      = Req0 ? GRANT0 : IDLE;
               beat_cnt_nxt   = 4'd0;
               last_grant_nxt = 1'b1;
            end else if (hold_hit) begin
               beat_cnt_nxt = 4'd0;
               if (Req0) begin
                  state_nxt      = GRANT0;
                  last_grant_nxt = 1'b1;
               end
            end else if (acc1) begin
               beat_cnt_nxt = beat_inc;
            end
         end
         default: begin
            state_nxt    = IDLE;
            beat_cnt_nxt = 4'd0;
         end
      endcase
      // Selector follows the grant and keeps its last value while idle.
      if (state_nxt == GRANT1)      sel_nxt = 1'b1;
      else if (state_nxt == GRANT0) sel_nxt = 1'b0;
      else                          sel_nxt = Selector;
   end

   // Control registers: FSM state, beat counter, tie-break history, selector.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         beat_cnt   <= 4'd0;
         last_grant <= 1'b1;
         Selector   <= 1'b0;
      end else begin
         state      <= state_nxt;
         beat_cnt   <= beat_cnt_nxt;
         last_grant <= last_grant_nxt;
         Selector   <= sel_nxt;
      end
   end

   // Output slot: capture on accept, otherwise drain on consume.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         DataOut <= '0;
         Valid   <= 1'b0;
      end else if (acc0) begin
         DataOut <= In0;
         Valid   <= 1'b1;
      end else if (acc1) begin
         DataOut <= In1;
         Valid   <= 1'b1;
      end else if (Valid && Ready) begin
         Valid <= 1'b0;
      end
   end

`ifdef MUX_ARB_COUNT_EN
   // Per-requester ack counters, free-running modulo 256.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         Count0 <= 8'd0;
         Count1 <= 8'd0;
      end else begin
         if (acc0) Count0 <= Count0 + 8'd1;
         if (acc1) Count1 <= Count1 + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: table vectors, directed corner sequences and a randomized
// run against a behavioural model of the arbiter.
module tb_mux_arbiter;

   localparam int WIDTH    = 4;
   localparam int MAX_HOLD = 4;

   logic             Clock, nReset;
   logic             Req0, Req1, Ready;
   logic [WIDTH-1:0] In0, In1;
   logic             Ack0, Ack1, Selector, Valid;
   logic [WIDTH-1:0] DataOut;
   logic [1:0]       dbg_state;
`ifdef MUX_ARB_COUNT_EN
   logic [7:0]       Count0, Count1;
`endif

   mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .Clock(Clock), .nReset(nReset),
      .Req0(Req0), .In0(In0), .Req1(Req1), .In1(In1),
      .Ack0(Ack0), .Ack1(Ack1), .Selector(Selector),
      .DataOut(DataOut), .Valid(Valid), .Ready(Ready),
      .dbg_state(dbg_state)
`ifdef MUX_ARB_COUNT_EN
      , .Count0(Count0), .Count1(Count1)
`endif
   );

   // Clock
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the channel, beats taken, output slot contents.
   int               m_owner;   // -1 none, 0 or 1
   int               m_beats;
   int               m_last;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_sel;
   int               m_cnt0, m_cnt1;

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_last = 1;
      m_valid = 1'b0; m_data = '0; m_sel = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
   endtask

   function automatic logic m_ack(input int k);
      logic r;
      r = (k == 0) ? Req0 : Req1;
      return (m_owner == k) && r && (!m_valid || Ready);
   endfunction

   task automatic model_check();
      chk("model_ack0", {31'd0, Ack0}, {31'd0, m_ack(0)});
      chk("model_ack1", {31'd0, Ack1}, {31'd0, m_ack(1)});
      chk("model_valid", {31'd0, Valid}, {31'd0, m_valid});
      chk("model_data", 32'(DataOut), 32'(m_data));
      chk("model_sel", {31'd0, Selector}, {31'd0, m_sel});
`ifdef MUX_ARB_COUNT_EN
      chk("model_count0", 32'(Count0), 32'(m_cnt0 % 256));
      chk("model_count1", 32'(Count1), 32'(m_cnt1 % 256));
`endif
   endtask

   task automatic model_update();
      logic a0, a1, rq_own, rq_oth;
      int   oth;
      a0 = m_ack(0);
      a1 = m_ack(1);
      if (a0) begin m_data = In0; m_valid = 1'b1; m_cnt0++; end
      else if (a1) begin m_data = In1; m_valid = 1'b1; m_cnt1++; end
      else if (m_valid && Ready) m_valid = 1'b0;
      if (m_owner < 0) begin
         if (Req0 && Req1) m_owner = (m_last == 1) ? 0 : 1;
         else if (Req0)    m_owner = 0;
         else if (Req1)    m_owner = 1;
      end else begin
         oth    = 1 - m_owner;
         rq_own = (m_owner == 0) ? Req0 : Req1;
         rq_oth = (oth == 0) ? Req0 : Req1;
         if (!rq_own) begin
            m_last = m_owner; m_beats = 0;
            m_owner = rq_oth ? oth : -1;
         end else if (a0 || a1) begin
            m_beats++;
            if (m_beats == MAX_HOLD) begin
               m_beats = 0;
               if (rq_oth) begin m_last = m_owner; m_owner = oth; end
            end
         end
      end
      if (m_owner == 1)      m_sel = 1'b1;
      else if (m_owner == 0) m_sel = 1'b0;
   endtask

   // Driver: apply inputs just after an edge, settle to the falling edge.
   task automatic apply(input logic r0, input logic [WIDTH-1:0] i0,
                        input logic r1, input logic [WIDTH-1:0] i1, input logic rdy);
      Req0 = r0; In0 = i0; Req1 = r1; In1 = i1; Ready = rdy;
      @(negedge Clock);
   endtask

   task automatic advance();
      model_update();
      @(posedge Clock);
      #1;
   endtask

   task automatic step(input logic r0, input logic [WIDTH-1:0] i0,
                       input logic r1, input logic [WIDTH-1:0] i1, input logic rdy);
      apply(r0, i0, r1, i1, rdy);
      model_check();
      advance();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
   task automatic do_reset();
      Req0 = 1'b0; Req1 = 1'b0; In0 = '0; In1 = '0; Ready = 1'b0;
      #2;
      nReset = 1'b0;
      #1;
      chk("rst_valid", {31'd0, Valid}, 32'd0);
      chk("rst_data", 32'(DataOut), 32'd0);
      chk("rst_sel", {31'd0, Selector}, 32'd0);
      chk("rst_ack0", {31'd0, Ack0}, 32'd0);
      chk("rst_ack1", {31'd0, Ack1}, 32'd0);
      model_reset();
      @(posedge Clock);
      #1;
      nReset = 1'b1;
   endtask

   typedef struct {
      logic             r0;
      logic [WIDTH-1:0] i0;
      logic             r1;
      logic [WIDTH-1:0] i1;
      logic             rdy;
      logic             e_ack0;
      logic             e_ack1;
      logic             e_valid;
      logic [WIDTH-1:0] e_data;
      logic             e_sel;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // Tie from reset, release, backpressure, hand-back, drain.
      tbl[0] = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
      tbl[1] = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
      tbl[2] = '{1'b0, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0};
      tbl[3] = '{1'b0, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1};
      tbl[4] = '{1'b1, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1};
      tbl[5] = '{1'b1, 4'hA, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1};
      tbl[6] = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0};
      tbl[7] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0};
      tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0};
      tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0};

      nReset = 1'b1;
      Req0 = 1'b0; Req1 = 1'b0; In0 = '0; In1 = '0; Ready = 1'b0;
      @(posedge Clock);
      #1;
      do_reset();

      // Table vectors
      for (int v = 0; v < 10; v++) begin
         apply(tbl[v].r0, tbl[v].i0, tbl[v].r1, tbl[v].i1, tbl[v].rdy);
         chk($sformatf("tbl%0d_ack0", v), {31'd0, Ack0}, {31'd0, tbl[v].e_ack0});
         chk($sformatf("tbl%0d_ack1", v), {31'd0, Ack1}, {31'd0, tbl[v].e_ack1});
         chk($sformatf("tbl%0d_valid", v), {31'd0, Valid}, {31'd0, tbl[v].e_valid});
         chk($sformatf("tbl%0d_data", v), 32'(DataOut), 32'(tbl[v].e_data));
         chk($sformatf("tbl%0d_sel", v), {31'd0, Selector}, {31'd0, tbl[v].e_sel});
         advance();
      end

      // Hold limit: both requesting, Ready high -> blocks of MAX_HOLD acks alternate.
      do_reset();
      for (int c = 0; c < 4 * MAX_HOLD + 1; c++) begin
         logic e0, e1;
         apply(1'b1, 4'(c), 1'b1, 4'(c + 8), 1'b1);
         e0 = (c >= 1) && (((c - 1) / MAX_HOLD) % 2 == 0);
         e1 = (c >= 1) && !e0;
         chk($sformatf("hold%0d_ack0", c), {31'd0, Ack0}, {31'd0, e0});
         chk($sformatf("hold%0d_ack1", c), {31'd0, Ack1}, {31'd0, e1});
         chk($sformatf("hold%0d_sel", c), {31'd0, Selector}, {31'd0, e1});
         model_check();
         advance();
      end

      // Backpressure: slot full and Ready low freezes the channel.
      do_reset();
      apply(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
      chk("bp_idle_ack0", {31'd0, Ack0}, 32'd0);
      advance();
      apply(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
      chk("bp_first_ack0", {31'd0, Ack0}, 32'd1);
      advance();
      for (int c = 0; c < 3; c++) begin
         apply(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
         chk($sformatf("bp_stall%0d_ack0", c), {31'd0, Ack0}, 32'd0);
         chk($sformatf("bp_stall%0d_data", c), 32'(DataOut), 32'h3);
         chk($sformatf("bp_stall%0d_valid", c), {31'd0, Valid}, 32'd1);
         model_check();
         advance();
      end
      apply(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
      chk("bp_release_ack0", {31'd0, Ack0}, 32'd1);
      advance();
      apply(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      chk("bp_after_data", 32'(DataOut), 32'h7);
      chk("bp_after_valid", {31'd0, Valid}, 32'd1);
      advance();

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0));
      end

      // Reset while a beat is pending.
      do_reset();

`ifdef MUX_ARB_COUNT_EN
      // 300 acks to requester 0: counter wraps to 44.
      for (int c = 0; c < 301; c++) begin
         apply(1'b1, 4'(c), 1'b0, 4'h0, 1'b1);
         advance();
      end
      apply(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      chk("count0_wrap", 32'(Count0), 32'd44);
      chk("count1_zero", 32'(Count1), 32'd0);
      model_check();
      advance();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
